// File: rtl/tl_sensor_cond.sv
// Sensor conditioning for a two-road traffic controller: synchronizes and debounces
// four car sensors and enforces min/max green length on the active channel.
module tl_sensor_cond #(
  parameter int unsigned DEB_CNT   = 4,
  parameter int unsigned MIN_GREEN = 8,
  parameter int unsigned MAX_GREEN = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       raw_a,
  input  logic       raw_al,
  input  logic       raw_b,
  input  logic       raw_bl,
  input  logic [2:0] q,
  output logic       Ta,
  output logic       Tal,
  output logic       Tb,
  output logic       Tbl,
  output logic [5:0] elapsed,
  output logic       max_cut
);

  // Channel index 0..3 = A, A-left, B, B-left, which is also q[2:1] of that green.
  logic [3:0] raw;
  logic [3:0] sync1, sync2, deb;
  logic [3:0] dcnt [4];
  logic [2:0] q_d;
  logic [5:0] cnt;
  logic       phase_new;
  logic [3:0] t;

  assign raw       = {raw_bl, raw_b, raw_al, raw_a};
  assign phase_new = (q != q_d);
  assign elapsed   = phase_new ? '0 : cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      for (int unsigned i = 0; i < 4; i++) dcnt[i] <= '0;
      q_d   <= '0;
      cnt   <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      for (int unsigned i = 0; i < 4; i++) begin
        if (sync2[i] != deb[i]) begin
          if (dcnt[i] == 4'(DEB_CNT - 1)) begin
            deb[i]  <= sync2[i];
            dcnt[i] <= '0;
          end else begin
            dcnt[i] <= dcnt[i] + 4'd1;
          end
        end else begin
          dcnt[i] <= '0;
        end
      end
      q_d <= q;
      // Count starts at 1 on the edge leaving the first cycle of a phase (elapsed 0).
      if (phase_new)
        cnt <= 6'd1;
      else if (!q[0] && (cnt < 6'(MAX_GREEN - 1)))
        cnt <= cnt + 6'd1;
    end
  end

  always_comb begin
    t       = deb;
    max_cut = 1'b0;
    if (!q[0]) begin
      if (elapsed < 6'(MIN_GREEN - 1)) begin
        t[q[2:1]] = 1'b1;
      end else if (elapsed >= 6'(MAX_GREEN - 1)) begin
        t[q[2:1]] = 1'b0;
        max_cut   = 1'b1;
      end
    end
  end

  assign Ta  = t[0];
  assign Tal = t[1];
  assign Tb  = t[2];
  assign Tbl = t[3];

endmodule
